p4_router_ingress_port_adapter: RTL and testbench

Per-physical-port AXIS width upsizer that sits directly upstream of the P4 router ingress buffer. Packs narrow beats from one ingress physical port into full-width ingress-bus words, with tkeep describing valid bytes. Enforces a maximum packet length by truncating, and flags malformed input. One instance per ingress port; its output drives one element of the adapted-port array consumed by the ingress buffer.

---
 rtl/p4_router_ingress_port_adapter.sv | 203 ++++++++++++++++++++
 tb/tb_p4_router_ingress_port_adapter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p4_router_ingress_port_adapter.sv
// rtl/p4_router_ingress_port_adapter.sv - per-port AXIS upsizer with max-length truncation and framing checks
// Optional runt padding to MIN_PKT_BYTES is enabled by defining P4_ING_ADAPT_RUNT_PAD_EN.
module p4_router_ingress_port_adapter #(
  parameter int IN_BYTES      = 8,
  parameter int OUT_BYTES     = 64,
  parameter int MAX_PKT_BYTES = 9600,
  parameter int MIN_PKT_BYTES = 64
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [8*IN_BYTES-1:0]  s_tdata,
  input  logic [IN_BYTES-1:0]    s_tkeep,
  input  logic                   s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [8*OUT_BYTES-1:0] m_tdata,
  output logic [OUT_BYTES-1:0]   m_tkeep,
  output logic                   m_tlast,
  output logic                   oversize_err,
  output logic                   framing_err
);

  localparam int R   = OUT_BYTES / IN_BYTES;
  localparam int IW  = (R > 1) ? $clog2(R) : 1;
  localparam int CW  = $clog2(MAX_PKT_BYTES + 1);
  localparam int PCW = $clog2(IN_BYTES + 1);
  localparam int LW  = 8 * IN_BYTES;
  localparam logic [CW:0] MAX_C = (CW+1)'(MAX_PKT_BYTES);

  if (IN_BYTES < 1 || (IN_BYTES & (IN_BYTES - 1)) != 0) begin : g_chk_in
    $error("IN_BYTES must be a power of 2");
  end
  if (OUT_BYTES < IN_BYTES || (OUT_BYTES % IN_BYTES) != 0) begin : g_chk_out
    $error("OUT_BYTES must be a multiple of IN_BYTES");
  end
  if (MAX_PKT_BYTES < OUT_BYTES) begin : g_chk_max
    $error("MAX_PKT_BYTES must be >= OUT_BYTES");
  end
  if (MIN_PKT_BYTES < 1 || MIN_PKT_BYTES > MAX_PKT_BYTES) begin : g_chk_min
    $error("MIN_PKT_BYTES must lie in 1..MAX_PKT_BYTES");
  end

  typedef enum logic [1:0] {
    PACK,
    DISCARD
`ifdef P4_ING_ADAPT_RUNT_PAD_EN
    , PAD
`endif
  } state_t;

  function automatic logic [PCW-1:0] popcount(input logic [IN_BYTES-1:0] k);
    logic [PCW-1:0] c;
    c = '0;
    for (int i = 0; i < IN_BYTES; i++) c = c + PCW'(k[i]);
    return c;
  endfunction

  function automatic logic [IN_BYTES-1:0] lane_mask(input logic [PCW-1:0] n);
    logic [IN_BYTES-1:0] m;
    for (int i = 0; i < IN_BYTES; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  state_t                     state;
  logic [IW-1:0]              idx;
  logic [CW-1:0]              count;
  logic [R-1:0][LW-1:0]       acc_data;
  logic [R-1:0][IN_BYTES-1:0] acc_keep;

  logic                       accept, pack_beat, over, complete, bad_keep;
  logic [PCW-1:0]             pc, n_bytes;
  logic [CW:0]                sum, room;
  logic [IN_BYTES-1:0]        beat_keep;
  logic [LW-1:0]              beat_data;
  logic [R-1:0][LW-1:0]       w_data;
  logic [R-1:0][IN_BYTES-1:0] w_keep;

`ifdef P4_ING_ADAPT_RUNT_PAD_EN
  localparam logic [CW:0] MIN_C = (CW+1)'(MIN_PKT_BYTES);
  localparam logic [CW:0] OUT_C = (CW+1)'(OUT_BYTES);

  function automatic logic [OUT_BYTES-1:0] word_mask(input logic [CW:0] n);
    logic [OUT_BYTES-1:0] m;
    for (int i = 0; i < OUT_BYTES; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  logic [CW-1:0] word_base;
  logic [CW-1:0] pad_left;
  logic          runt;
  logic [CW:0]   head;

  // head: bytes still owed to reach the minimum, counted from the start of the current word
  assign runt = s_tlast & ~over & (sum < MIN_C);
  assign head = MIN_C - {1'b0, word_base};
  assign s_tready = (state == DISCARD) | ((state == PACK) & (~m_tvalid | m_tready));
`else
  assign s_tready = (state == DISCARD) | ~m_tvalid | m_tready;
`endif

  assign accept    = s_tvalid & s_tready;
  assign pack_beat = accept & (state == PACK);
  assign pc        = popcount(s_tkeep);
  assign sum       = {1'b0, count} + (CW+1)'(pc);
  assign room      = MAX_C - {1'b0, count};
  // A last beat that lands exactly on the limit is legal; anything beyond is trimmed.
  assign over      = s_tlast ? (sum > MAX_C) : (sum >= MAX_C);
  assign n_bytes   = over ? PCW'(room) : pc;
  assign beat_keep = lane_mask(n_bytes);
  assign complete  = pack_beat & ((idx == IW'(R - 1)) | s_tlast | over);
  assign bad_keep  = (s_tkeep == '0) | (~s_tlast & (s_tkeep != '1));

  always_comb begin
    beat_data = '0;
    for (int b = 0; b < IN_BYTES; b++)
      beat_data[8*b +: 8] = beat_keep[b] ? s_tdata[8*b +: 8] : 8'h00;
    w_data      = acc_data;
    w_keep      = acc_keep;
    w_data[idx] = beat_data;
    w_keep[idx] = beat_keep;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= PACK;
      idx          <= '0;
      count        <= '0;
      acc_data     <= '0;
      acc_keep     <= '0;
      m_tvalid     <= 1'b0;
      m_tdata      <= '0;
      m_tkeep      <= '0;
      m_tlast      <= 1'b0;
      oversize_err <= 1'b0;
      framing_err  <= 1'b0;
`ifdef P4_ING_ADAPT_RUNT_PAD_EN
      word_base    <= '0;
      pad_left     <= '0;
`endif
    end else begin
      oversize_err <= pack_beat & over;
      framing_err  <= accept & bad_keep;
      if (m_tvalid & m_tready) m_tvalid <= 1'b0;
      case (state)
        PACK: if (pack_beat) begin
          count <= (s_tlast | over) ? '0 : sum[CW-1:0];
          if (complete) begin
            m_tvalid <= 1'b1;
            m_tdata  <= w_data;
            m_tkeep  <= w_keep;
            m_tlast  <= s_tlast | over;
            acc_data <= '0;
            acc_keep <= '0;
            idx      <= '0;
          end else begin
            acc_data[idx] <= beat_data;
            acc_keep[idx] <= beat_keep;
            idx           <= idx + IW'(1);
          end
          if (over & ~s_tlast) state <= DISCARD;
`ifdef P4_ING_ADAPT_RUNT_PAD_EN
          if (complete) word_base <= (s_tlast | over) ? '0 : sum[CW-1:0];
          if (runt) begin
            if (head > OUT_C) begin
              m_tkeep  <= '1;
              m_tlast  <= 1'b0;
              pad_left <= CW'(head - OUT_C);
              state    <= PAD;
            end else begin
              m_tkeep  <= word_mask(head);
            end
          end
`endif
        end
        DISCARD: if (accept & s_tlast) begin
          state <= PACK;
          idx   <= '0;
          count <= '0;
        end
`ifdef P4_ING_ADAPT_RUNT_PAD_EN
        PAD: if (~m_tvalid | m_tready) begin
          m_tvalid <= 1'b1;
          m_tdata  <= '0;
          if ({1'b0, pad_left} > OUT_C) begin
            m_tkeep  <= '1;
            m_tlast  <= 1'b0;
            pad_left <= pad_left - OUT_C[CW-1:0];
          end else begin
            m_tkeep  <= word_mask({1'b0, pad_left});
            m_tlast  <= 1'b1;
            pad_left <= '0;
            state    <= PACK;
          end
        end
`endif
        default: state <= PACK;
      endcase
    end
  end

endmodule

// File: tb/tb_p4_router_ingress_port_adapter.sv
// tb/tb_p4_router_ingress_port_adapter.sv - directed self-checking bench for the ingress port adapter
module tb_p4_router_ingress_port_adapter;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic         v0 = 1'b0, v1 = 1'b0, r0 = 1'b0, r1 = 1'b0, tog_en = 1'b0;
  logic [63:0]  s_tdata = '0;
  logic [7:0]   s_tkeep = '0;
  logic         s_tlast = 1'b0;
  logic         rdy0, mv0, ml0, ov0, fe0;
  logic         rdy1, mv1, ml1, ov1, fe1;
  logic [511:0] md0, md1;
  logic [63:0]  mk0, mk1;

  int passed = 0;
  int total  = 0;
  int stab_err = 0, rdy_err = 0, ov_cnt0 = 0, ov_cnt1 = 0, fe_cnt0 = 0;

  logic [511:0] qd0[$], qd1[$];
  logic [63:0]  qk0[$], qk1[$];
  logic         ql0[$], ql1[$];
  logic         prev_stall = 1'b0;
  logic [511:0] pd;
  logic [63:0]  pk;
  logic         pl;

  p4_router_ingress_port_adapter dut0 (
    .clk(clk), .aresetn(aresetn), .s_tvalid(v0), .s_tready(rdy0), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .m_tvalid(mv0), .m_tready(r0), .m_tdata(md0),
    .m_tkeep(mk0), .m_tlast(ml0), .oversize_err(ov0), .framing_err(fe0));

  p4_router_ingress_port_adapter #(.MAX_PKT_BYTES(128)) dut1 (
    .clk(clk), .aresetn(aresetn), .s_tvalid(v1), .s_tready(rdy1), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .m_tvalid(mv1), .m_tready(r1), .m_tdata(md1),
    .m_tkeep(mk1), .m_tlast(ml1), .oversize_err(ov1), .framing_err(fe1));

  always #5 clk = ~clk;

  always @(negedge clk) if (tog_en) r0 = ~r0;

  // Output monitor: samples just before each rising edge, records handshaken words.
  always @(negedge clk) begin
    #3;
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (mv0 !== 1'b1 || md0 !== pd || mk0 !== pk || ml0 !== pl)) stab_err++;
      if (rdy0 !== 1'b1 && !(mv0 && !r0)) rdy_err++;
      if (mv0 && r0) begin qd0.push_back(md0); qk0.push_back(mk0); ql0.push_back(ml0); end
      if (mv1 && r1) begin qd1.push_back(md1); qk1.push_back(mk1); ql1.push_back(ml1); end
      ov_cnt0 += int'(ov0);
      ov_cnt1 += int'(ov1);
      fe_cnt0 += int'(fe0);
      prev_stall = mv0 && !r0;
      pd = md0; pk = mk0; pl = ml0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout required=finish");
    $fatal(1);
  end

  function automatic logic [7:0] bv(input int p, input int i);
    return 8'(p * 53 + i * 7 + 1);
  endfunction

  function automatic logic [511:0] exp_data(input int p, input int len, input int w);
    logic [511:0] d;
    for (int j = 0; j < 64; j++) d[8*j +: 8] = (w*64 + j < len) ? bv(p, w*64 + j) : 8'h00;
    return d;
  endfunction

  function automatic logic [63:0] exp_keep(input int len, input int w);
    logic [63:0] k;
    for (int j = 0; j < 64; j++) k[j] = (w*64 + j < len);
    return k;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input bit which);
    logic rdy;
    @(negedge clk);
    s_tdata = d; s_tkeep = k; s_tlast = l;
    if (which) v1 = 1'b1; else v0 = 1'b1;
    for (int g = 0; g < 200; g++) begin
      #1;
      rdy = which ? rdy1 : rdy0;
      @(posedge clk);
      if (rdy) return;
      @(negedge clk);
    end
    total++;
    $display("FAIL send_beat_timeout s_tready got=0 required=1");
  endtask

  task automatic idle();
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0; s_tlast = 1'b0; s_tkeep = '0; s_tdata = '0;
  endtask

  task automatic send_pkt(input int p, input int len, input bit which, input int bad);
    int nb;
    logic [63:0] d;
    logic [7:0] k;
    nb = (len + 7) / 8;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < 8; j++) k[j] = (8*i + j < len);
      if (i == bad) k = 8'h0F;
      for (int j = 0; j < 8; j++) d[8*j +: 8] = k[j] ? bv(p, 8*i + j) : 8'h00;
      send_beat(d, k, (i == nb - 1), which);
    end
  endtask

  task automatic clear_q();
    qd0.delete(); qk0.delete(); ql0.delete();
    qd1.delete(); qk1.delete(); ql1.delete();
  endtask

  task automatic drain();
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (mv0 !== 1'b0) $display("FAIL reset_m_tvalid got=%0b required=0", mv0); else passed++;
    total++; if (ml0 !== 1'b0 || mk0 !== 64'h0) $display("FAIL reset_last_keep got=%0b/%h required=0/0", ml0, mk0); else passed++;
    total++; if (md0 !== 512'h0) $display("FAIL reset_m_tdata got=%h required=0", md0); else passed++;
    total++; if (ov0 !== 1'b0 || fe0 !== 1'b0) $display("FAIL reset_errs got=%0b%0b required=00", ov0, fe0); else passed++;
    total++; if (rdy0 !== 1'b1) $display("FAIL reset_s_tready got=%0b required=1", rdy0); else passed++;
    @(negedge clk);
    aresetn = 1'b1; r0 = 1'b1; r1 = 1'b1;
  endtask

  task automatic test_single_64();
    logic [63:0] d;
    clear_q();
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) d[8*j +: 8] = bv(1, 8*i + j);
      send_beat(d, 8'hFF, (i == 7), 1'b0);
      #1;
      if (i == 6) begin
        total++; if (mv0 !== 1'b0) $display("FAIL single_early_valid got=%0b required=0", mv0); else passed++;
      end
    end
    total++; if (mv0 !== 1'b1 || ml0 !== 1'b1) $display("FAIL single_latency valid/last got=%0b/%0b required=1/1", mv0, ml0); else passed++;
    total++; if (mk0 !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL single_keep got=%h required=ffffffffffffffff", mk0); else passed++;
    total++; if (md0 !== exp_data(1, 64, 0)) $display("FAIL single_data got=%h required=%h", md0, exp_data(1, 64, 0)); else passed++;
    idle(); drain();
    total++; if (qd0.size() != 1) $display("FAIL single_count got=%0d required=1", qd0.size()); else passed++;
  endtask

  task automatic test_100b();
    logic [63:0] ek[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_000F_FFFF_FFFF};
    logic        el[2] = '{1'b0, 1'b1};
    clear_q();
    send_pkt(2, 100, 1'b0, -1);
    idle(); drain();
    total++; if (qd0.size() != 2) $display("FAIL p100_count got=%0d required=2", qd0.size()); else passed++;
    for (int w = 0; w < 2; w++) begin
      total++;
      if (w >= qd0.size()) $display("FAIL p100_word%0d missing got=none required=word", w);
      else if (qd0[w] !== exp_data(2, 100, w) || qk0[w] !== ek[w] || ql0[w] !== el[w])
        $display("FAIL p100_word%0d keep/last got=%h/%0b required=%h/%0b data got=%h required=%h",
                 w, qk0[w], ql0[w], ek[w], el[w], qd0[w], exp_data(2, 100, w));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    stab_err = 0; rdy_err = 0;
    tog_en = 1'b1;
    for (int p = 30; p < 34; p++) send_pkt(p, 64, 1'b0, -1);
    idle(); drain();
    tog_en = 1'b0; r0 = 1'b1;
    total++; if (qd0.size() != 4) $display("FAIL b2b_count got=%0d required=4", qd0.size()); else passed++;
    for (int w = 0; w < 4; w++) begin
      total++;
      if (w >= qd0.size()) $display("FAIL b2b_word%0d missing got=none required=word", w);
      else if (qd0[w] !== exp_data(30 + w, 64, 0) || qk0[w] !== 64'hFFFF_FFFF_FFFF_FFFF || ql0[w] !== 1'b1)
        $display("FAIL b2b_word%0d keep/last got=%h/%0b required=ffffffffffffffff/1 data got=%h required=%h",
                 w, qk0[w], ql0[w], qd0[w], exp_data(30 + w, 64, 0));
      else passed++;
    end
    total++; if (stab_err != 0) $display("FAIL b2b_stall_stable got=%0d required=0", stab_err); else passed++;
    total++; if (rdy_err != 0) $display("FAIL b2b_tready_drop got=%0d required=0", rdy_err); else passed++;
  endtask

  task automatic test_oversize();
    logic [63:0] ek[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic        el[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int          ep[5] = '{20, 20, 21, 22, 22};
    int          ew[5] = '{0, 1, 0, 0, 1};
    clear_q();
    ov_cnt1 = 0;
    send_pkt(20, 200, 1'b1, -1);
    send_pkt(21, 64, 1'b1, -1);
    idle(); drain();
    total++; if (ov_cnt1 != 1) $display("FAIL over_pulse got=%0d required=1", ov_cnt1); else passed++;
    send_pkt(22, 128, 1'b1, -1);
    idle(); drain();
    total++; if (ov_cnt1 != 1) $display("FAIL over_exact_max got=%0d required=1", ov_cnt1); else passed++;
    total++; if (qd1.size() != 5) $display("FAIL over_count got=%0d required=5", qd1.size()); else passed++;
    for (int w = 0; w < 5; w++) begin
      total++;
      if (w >= qd1.size()) $display("FAIL over_word%0d missing got=none required=word", w);
      else if (qd1[w] !== exp_data(ep[w], 128, ew[w]) || qk1[w] !== ek[w] || ql1[w] !== el[w])
        $display("FAIL over_word%0d keep/last got=%h/%0b required=%h/%0b data got=%h required=%h",
                 w, qk1[w], ql1[w], ek[w], el[w], qd1[w], exp_data(ep[w], 128, ew[w]));
      else passed++;
    end
  endtask

  task automatic test_framing();
    logic [63:0] ek;
`ifdef P4_ING_ADAPT_RUNT_PAD_EN
    ek = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    ek = 64'hFFFF_FFFF_FF0F_FFFF;
`endif
    clear_q();
    fe_cnt0 = 0;
    send_pkt(40, 64, 1'b0, 2);
    idle(); drain();
    total++; if (fe_cnt0 != 1) $display("FAIL framing_pulse got=%0d required=1", fe_cnt0); else passed++;
    total++;
    if (qd0.size() != 1) $display("FAIL framing_count got=%0d required=1", qd0.size());
    else if (qk0[0] !== ek || ql0[0] !== 1'b1) $display("FAIL framing_keep got=%h/%0b required=%h/1", qk0[0], ql0[0], ek);
    else passed++;
    total++; if (ov_cnt0 != 0) $display("FAIL framing_no_oversize got=%0d required=0", ov_cnt0); else passed++;
  endtask

  task automatic test_runt();
    logic [63:0] ek;
`ifdef P4_ING_ADAPT_RUNT_PAD_EN
    ek = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    ek = 64'h0000_00FF_FFFF_FFFF;
`endif
    clear_q();
    send_pkt(50, 40, 1'b0, -1);
    idle(); drain();
    total++;
    if (qd0.size() != 1) $display("FAIL runt_count got=%0d required=1", qd0.size());
    else if (qd0[0] !== exp_data(50, 40, 0) || qk0[0] !== ek || ql0[0] !== 1'b1)
      $display("FAIL runt_word keep/last got=%h/%0b required=%h/1 data got=%h required=%h",
               qk0[0], ql0[0], ek, qd0[0], exp_data(50, 40, 0));
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    clear_q();
    r0 = 1'b0;
    send_pkt(10, 64, 1'b0, -1);
    idle();
    #1;
    total++; if (mv0 !== 1'b1) $display("FAIL rstmid_held got=%0b required=1", mv0); else passed++;
    #1 aresetn = 1'b0;
    #1;
    total++; if (mv0 !== 1'b0 || mk0 !== 64'h0 || md0 !== 512'h0 || ml0 !== 1'b0)
      $display("FAIL rstmid_async valid/keep/last got=%0b/%h/%0b required=0/0/0", mv0, mk0, ml0); else passed++;
    @(negedge clk);
    aresetn = 1'b1; r0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 8; j++) d[8*j +: 8] = bv(11, 8*i + j);
      send_beat(d, 8'hFF, 1'b0, 1'b0);
    end
    idle();
    #2 aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    clear_q();
    send_pkt(12, 64, 1'b0, -1);
    idle(); drain();
    total++;
    if (qd0.size() != 1) $display("FAIL rstmid_count got=%0d required=1", qd0.size());
    else if (qd0[0] !== exp_data(12, 64, 0) || qk0[0] !== 64'hFFFF_FFFF_FFFF_FFFF || ql0[0] !== 1'b1)
      $display("FAIL rstmid_word keep/last got=%h/%0b required=ffffffffffffffff/1 data got=%h required=%h",
               qk0[0], ql0[0], qd0[0], exp_data(12, 64, 0));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_64();
    test_100b();
    test_back_to_back();
    test_oversize();
    test_framing();
    test_runt();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
